// File: rtl/datapath_ctrl_pkg.sv
// Shared types and encodings for the datapath controller: FSM states,
// instruction classes, opcode/op field values and ALU operation codes.
package datapath_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE    = 3'd0,
    CL_MOV_IMM = 3'd1,
    CL_MOV_REG = 3'd2,
    CL_ADD     = 3'd3,
    CL_CMP     = 3'd4,
    CL_AND     = 3'd5,
    CL_MVN     = 3'd6
  } instr_cls_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  function automatic logic signed [DATA_W-1:0] sext8(input logic [7:0] v);
    return {{(DATA_W-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/datapath_ctrl_instr_dec.sv
// Combinational instruction decoder: splits the instruction register into
// its fields and classifies the encoding into one supported instruction.
module instr_dec
  import datapath_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] ir,
  output logic [REG_W-1:0]  rn,
  output logic [REG_W-1:0]  rd,
  output logic [REG_W-1:0]  rm,
  output logic [1:0]        sh,
  output logic [DATA_W-1:0] sximm8,
  output instr_cls_t        cls
);

  logic [2:0] opcode;
  logic [1:0] op;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = sext8(ir[7:0]);

  always_comb begin
    cls = CL_NONE;
    if (opcode == OPC_MOV) begin
      case (op)
        OP_MOV_IMM: cls = CL_MOV_IMM;
        OP_MOV_REG: cls = CL_MOV_REG;
        default:    cls = CL_NONE;
      endcase
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  cls = CL_ADD;
        OP_CMP:  cls = CL_CMP;
        OP_AND:  cls = CL_AND;
        OP_MVN:  cls = CL_MVN;
        default: cls = CL_NONE;
      endcase
    end
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle controller for a register-file/ALU datapath: holds the
// instruction register and sequences Moore control strobes per instruction.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              load,
  input  logic [DATA_W-1:0] in,
  output logic              w,
  output logic              vsel,
  output logic              write,
  output logic [REG_W-1:0]  writenum,
  output logic [REG_W-1:0]  readnum,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] datapath_in
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] ir;
  logic [REG_W-1:0]  rn;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  rm;
  logic [1:0]        sh;
  logic [DATA_W-1:0] sximm8;
  instr_cls_t        cls;

  function automatic logic [1:0] alu_op_of(input instr_cls_t c);
    case (c)
      CL_CMP:  return ALU_SUB;
      CL_AND:  return ALU_AND;
      CL_MVN:  return ALU_NOTB;
      default: return ALU_ADD;
    endcase
  endfunction

  instr_dec u_dec (
    .ir     (ir),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .sximm8 (sximm8),
    .cls    (cls)
  );

  // The IR only accepts a new word while idle, so an instruction in flight
  // always sees a stable encoding.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT && load)
        ir <= in;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:      state_nxt = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        case (cls)
          CL_MOV_IMM:             state_nxt = S_WRITE_IMM;
          CL_ADD, CL_CMP, CL_AND: state_nxt = S_GET_A;
          CL_MOV_REG, CL_MVN:     state_nxt = S_GET_B;
          default:                state_nxt = S_WAIT;
        endcase
      end
      S_GET_A:     state_nxt = S_GET_B;
      S_GET_B:     state_nxt = S_ALU;
      S_ALU:       state_nxt = (cls == CL_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_nxt = S_WAIT;
      S_WRITE_IMM: state_nxt = S_WAIT;
      default:     state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    w           = 1'b0;
    vsel        = 1'b0;
    write       = 1'b0;
    writenum    = '0;
    readnum     = '0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    shift       = 2'b00;
    ALUop       = ALU_ADD;
    datapath_in = sximm8;
    case (state)
      S_WAIT: w = 1'b1;
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = 1'b1;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        // Single-operand forms zero the A input so the B path passes through.
        shift = sh;
        ALUop = alu_op_of(cls);
        asel  = (cls == CL_MOV_REG) || (cls == CL_MVN);
        loadc = (cls != CL_CMP);
        loads = (cls == CL_CMP);
      end
      S_WRITE_REG: begin
        writenum = rd;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 Clock and reset SHALL be: clk input 1 (single clock, rising edge); reset input 1 (synchronous, active-high).
REQ-002 s input 1: start; sampled only in WAIT.
REQ-003 load input 1: instruction-register load enable.
REQ-004 in input 16: instruction word.
REQ-005 w output 1: high only in WAIT (ready).
REQ-006 The datapath control outputs SHALL be: vsel 1, write 1, writenum 3, readnum 3, loada 1, loadb 1, loadc 1, loads 1, asel 1, bsel 1, shift 2, ALUop 2.
REQ-007 datapath_in output 16: sign-extended imm8 of the IR, sximm8 = {{8{IR[7]}},IR[7:0]}.

Function
REQ-008 IR fields SHALL be: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
REQ-009 IR SHALL load from in on a rising edge with load=1 only while in WAIT; load is ignored in all other states.
REQ-010 Instructions SHALL be: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{sh}; 101/00 ADD Rd,Rn,Rm{sh}; 101/01 CMP Rn,Rm{sh}; 101/10 AND Rd,Rn,Rm{sh}; 101/11 MVN Rd,Rm{sh}.
REQ-011 The FSM SHALL have states WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG.
REQ-012 WAIT SHALL go to DECODE on s=1, else stay in WAIT.
REQ-013 DECODE SHALL go to WRITE_IMM for MOV imm, GET_A for ADD/CMP/AND, GET_B for MOV reg/MVN, and WAIT for any other encoding.
REQ-014 GET_A SHALL go to GET_B; GET_B to ALU; ALU to WAIT for CMP, else WRITE_REG; WRITE_REG and WRITE_IMM to WAIT.
REQ-015 Outputs SHALL be Moore, decoded from state plus IR; every strobe and select defaults to 0, readnum/writenum default 3'b000.
REQ-016 GET_A SHALL drive readnum=Rn, loada=1.
REQ-017 GET_B SHALL drive readnum=Rm, loadb=1.
REQ-018 ALU SHALL drive shift=sh and bsel=0, with per-instruction values:
- ALUop: ADD 00, CMP 01, AND 10, MVN 11, MOV reg 00.
- asel=1 for MOV reg and MVN, else 0.
- loadc=1 except CMP; loads=1 only for CMP.
REQ-019 WRITE_REG SHALL drive writenum=Rd, vsel=0, write=1.
REQ-020 WRITE_IMM SHALL drive writenum=Rn, vsel=1, write=1.
REQ-021 Latency from the edge sampling s (w deasserts the next cycle) SHALL be:
- MOV imm: 2 busy cycles.
- MOV reg/MVN: 4.
- CMP: 4.
- ADD/AND: 5.
- Unsupported: 1.
REQ-022 s and load high together in WAIT SHALL load IR and start; DECODE uses the new IR.
REQ-023 If s is held high, the FSM SHALL restart from WAIT on the cycle after returning to WAIT (w high for exactly one cycle).
REQ-024 write SHALL never assert in more than one cycle per instruction; unsupported encodings assert no strobes.

Reset
REQ-025 reset=1 at a rising edge SHALL force WAIT and IR=16'h0000, overriding s and load.
REQ-026 Reset values SHALL be: w=1, all strobes 0, datapath_in=16'h0000.
REQ-027 Reset mid-instruction SHALL abort it with no further write, loadc or loads strobe.

Structure
REQ-028 Package datapath_ctrl_pkg SHALL hold the state enum, the opcode/op constants and the ALUop constants (ADD, SUB, AND, NOTB).
REQ-029 Field extraction and instruction classification SHALL be one combinational sub-module, instr_dec; the FSM and IR stay in datapath_ctrl.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Load 16'hD32A (MOV R3,#42), pulse s -> WRITE_IMM cycle shows writenum=3, vsel=1, write=1, datapath_in=16'h002A; w high 2 cycles after the busy start.
- Load 16'hD1FF (MOV R1,#-1) -> datapath_in=16'hFFFF, writenum=1.
- With R3=42 and R5=13, load 16'hA543 (ADD R2,R5,R3):
  - loada with readnum=5, then loadb with readnum=3.
  - ALU cycle: ALUop=00, loadc=1.
  - write with writenum=2; datapath_out=55 when bound to datapath.
- Load 16'hAB03 (CMP R3,R3) -> ALUop=01, loads=1, loadc=0, write never 1; Z_out=1 on datapath.
- Load 16'h0000 and pulse s -> one busy cycle, zero strobes, w returns.
- Assert reset during GET_B of an ADD -> next cycle w=1, loadb=0, and no write follows; a load attempted mid-instruction leaves IR unchanged.
